// File: rtl/nios_system_leds_pkg.sv
// ============================================================================
// Module      : nios_system_leds_pkg
// Description : Register map word addresses for the LED output port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nios_system_leds_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

endpackage : nios_system_leds_pkg

`default_nettype wire

// File: rtl/nios_system_blink_timer.sv
// ============================================================================
// Module      : nios_system_blink_timer
// Description : Half-period counter and blink phase flop; idle when period=0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_system_blink_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] period,
    input  logic             load,
    output logic             phase
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_terminal;

    assign w_terminal = (r_cnt == (period - DIV_W'(1)));

    // A period load restarts the half-period even if it lands on terminal count.
    always_ff @(posedge clk) begin
        if (reset || load || (period == '0)) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_terminal) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + DIV_W'(1);
        end
    end

    assign phase = r_phase;

endmodule : nios_system_blink_timer

`default_nettype wire

// File: rtl/nios_system_leds_out.sv
// ============================================================================
// Module      : nios_system_leds_out
// Description : Avalon-MM LED output port with set/clear aliases and blink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_system_leds_out
    import nios_system_leds_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    DIV_W       = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_blink_en;
    logic [DIV_W-1:0]      r_period;
    logic [31:0]           r_readdata;
    logic [DATA_WIDTH-1:0] r_out;

    logic                  w_write;
    logic                  w_load;
    logic                  w_phase;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [31:0]           w_rdata;
    logic                  w_unused_ok;

    assign w_write     = chipselect & ~write_n;
    assign w_load      = w_write && (address == ADDR_PERIOD);
    assign w_wdata     = writedata[DATA_WIDTH-1:0];
    assign w_unused_ok = &{1'b0, writedata};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= RESET_VALUE;
            r_blink_en <= '0;
            r_period   <= '0;
        end else if (w_write) begin
            case (address)
                ADDR_DATA:     r_data     <= w_wdata;
                ADDR_BLINK_EN: r_blink_en <= w_wdata;
                ADDR_PERIOD:   r_period   <= writedata[DIV_W-1:0];
                ADDR_OUTSET:   r_data     <= r_data | w_wdata;
                ADDR_OUTCLEAR: r_data     <= r_data & ~w_wdata;
                default:       ;
            endcase
        end
    end

    nios_system_blink_timer #(
        .DIV_W (DIV_W)
    ) u_blink_timer (
        .clk    (clk),
        .reset  (reset),
        .period (r_period),
        .load   (w_load),
        .phase  (w_phase)
    );

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:     w_rdata[DATA_WIDTH-1:0] = r_data;
            ADDR_BLINK_EN: w_rdata[DATA_WIDTH-1:0] = r_blink_en;
            ADDR_PERIOD:   w_rdata[DIV_W-1:0]      = r_period;
            ADDR_STATUS:   w_rdata[0]              = w_phase;
            default:       w_rdata                 = '0;
        endcase
    end

    // Blinking bits are forced off during the high phase; DATA=0 bits stay off.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
            r_out      <= RESET_VALUE;
        end else begin
            r_readdata <= w_rdata;
            r_out      <= r_data & ~(r_blink_en & {DATA_WIDTH{w_phase}});
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;

endmodule : nios_system_leds_out

`default_nettype wire

// File: tb/tb_nios_system_leds_out.sv
// ============================================================================
// Module      : tb_nios_system_leds_out
// Description : Directed self-checking bench for the LED output port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nios_system_leds_out;

    localparam int             c_dw    = 8;
    localparam logic [7:0]     c_rst_v = 8'h5A;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_checks;
    int n_fail;

    nios_system_leds_out #(
        .DATA_WIDTH  (c_dw),
        .RESET_VALUE (c_rst_v),
        .DIV_W       (24)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // All tasks are entered at a falling edge and return at a falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        @(negedge clk);
        check(tag, readdata, exp);
    endtask

    logic [7:0]  exp_rd [8];
    logic        ph;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out", {24'h0, out_port}, 32'h5A);
        check("rst_rdata", readdata, 32'h0);
        reset = 1'b0;

        // 1: reset values of every address
        exp_rd = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++)
            rd(3'(i), {24'h0, exp_rd[i]}, $sformatf("rst_addr%0d", i));
        check("rst_out2", {24'h0, out_port}, 32'h5A);

        // 2: set/clear aliases
        wr(3'd0, 32'hFFFF_FFF0, 1'b1);
        wr(3'd4, 32'h0000_0003, 1'b1);
        wr(3'd5, 32'h0000_0030, 1'b1);
        check("sc_out_lag", {24'h0, out_port}, 32'hF3);
        @(negedge clk);
        check("sc_out", {24'h0, out_port}, 32'hC3);
        rd(3'd0, 32'hC3, "sc_data");
        rd(3'd4, 32'h0, "outset_rd0");
        rd(3'd5, 32'h0, "outclr_rd0");

        // 3: blink with half-period 4
        wr(3'd0, 32'hFF, 1'b1);
        wr(3'd1, 32'h0F, 1'b1);
        wr(3'd2, 32'h4, 1'b1);
        address = 3'd3;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ph = (((k - 1) / 4) % 2) == 1;
            check($sformatf("blink_out%0d", k), {24'h0, out_port}, ph ? 32'hF0 : 32'hFF);
            check($sformatf("blink_st%0d", k), readdata, {31'h0, ph});
        end

        // 4a: PERIOD=0 stops blinking with phase low
        wr(3'd2, 32'h0, 1'b1);
        address = 3'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stop_out%0d", k), {24'h0, out_port}, 32'hFF);
            check($sformatf("stop_st%0d", k), readdata, 32'h0);
        end

        // 4b: reload PERIOD on the terminal-count cycle
        wr(3'd2, 32'h4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        wr(3'd2, 32'h2, 1'b1);
        address = 3'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reload_out%0d", k), {24'h0, out_port}, (k == 2) ? 32'hF0 : 32'hFF);
            check($sformatf("reload_st%0d", k), readdata, (k == 2) ? 32'h1 : 32'h0);
        end

        // 5: reset mid-blink beats a simultaneous DATA write
        reset = 1'b1;
        wr(3'd0, 32'h11, 1'b1);
        reset = 1'b0;
        check("mrst_out", {24'h0, out_port}, 32'h5A);
        check("mrst_rdata", readdata, 32'h0);
        rd(3'd0, 32'h5A, "mrst_data");
        rd(3'd1, 32'h0, "mrst_blink");
        rd(3'd2, 32'h0, "mrst_period");
        rd(3'd3, 32'h0, "mrst_status");
        check("mrst_out2", {24'h0, out_port}, 32'h5A);

        // 6: unselected and unmapped writes
        wr(3'd6, 32'hFF, 1'b0);
        wr(3'd7, 32'hFF, 1'b1);
        wr(3'd0, 32'h33, 1'b0);
        wr(3'd3, 32'h1, 1'b1);
        rd(3'd6, 32'h0, "addr6_rd");
        rd(3'd7, 32'h0, "addr7_rd");
        rd(3'd0, 32'h5A, "ign_data");
        rd(3'd1, 32'h0, "ign_blink");
        rd(3'd2, 32'h0, "ign_period");
        rd(3'd3, 32'h0, "ign_status");
        check("ign_out", {24'h0, out_port}, 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nios_system_leds_out

`default_nettype wire
